// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative one-bit-per-clock MULT/MULTU/DIV/DIVU unit with HI/LO result registers
module mult_div_unit #(
    parameter int N  = 32,
    parameter int CW = 6
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         start,
    input  logic [1:0]   op,
    input  logic [N-1:0] inA,
    input  logic [N-1:0] inB,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] hi,
    output logic [N-1:0] lo,
    output logic         div_by_zero
);

    typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_t          state, state_next;
    logic [CW-1:0]   count;
    logic            is_div;
    logic            neg_lo;
    logic            neg_hi;
    logic [N-1:0]    a_orig;
    logic [N-1:0]    opnd;
    logic [2*N-1:0]  acc;

    logic            a_neg, b_neg;
    logic [N-1:0]    a_mag, b_mag;
    logic [N:0]      mul_sum;
    logic [2*N-1:0]  mul_next;
    logic [N:0]      div_shift;
    logic [N:0]      div_diff;
    logic            div_ge;
    logic [2*N-1:0]  div_next;
    logic [2*N-1:0]  product;
    logic [N-1:0]    quot, rem;
    logic [N-1:0]    res_hi, res_lo;
    logic            res_dbz;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (count == LAST) state_next = FINISH;
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    // op[0]==0 selects the signed variants
    assign a_neg = ~op[0] & inA[N-1];
    assign b_neg = ~op[0] & inB[N-1];
    assign a_mag = a_neg ? (~inA + 1'b1) : inA;
    assign b_mag = b_neg ? (~inB + 1'b1) : inB;

    // Multiply: multiplier sits in acc low half, shifted out LSB-first while product fills from the top
    assign mul_sum  = {1'b0, acc[2*N-1:N]} + (acc[0] ? {1'b0, opnd} : {(N+1){1'b0}});
    assign mul_next = {mul_sum, acc[N-1:1]};

    // Divide: acc = {partial remainder, dividend bits shifting into quotient bits}
    assign div_shift = {acc[2*N-1:N], acc[N-1]};
    assign div_ge    = (div_shift >= {1'b0, opnd});
    assign div_diff  = div_shift - {1'b0, opnd};
    assign div_next  = {(div_ge ? div_diff[N-1:0] : div_shift[N-1:0]), acc[N-2:0], div_ge};

    always_comb begin
        product = neg_lo ? (~acc + 1'b1) : acc;
        quot    = neg_lo ? (~acc[N-1:0] + 1'b1) : acc[N-1:0];
        rem     = neg_hi ? (~acc[2*N-1:N] + 1'b1) : acc[2*N-1:N];
        res_dbz = is_div && (opnd == '0);
        res_hi  = product[2*N-1:N];
        res_lo  = product[N-1:0];
        if (res_dbz) begin
            res_hi = a_orig;
            res_lo = '1;
        end else if (is_div) begin
            res_hi = rem;
            res_lo = quot;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count       <= '0;
            is_div      <= 1'b0;
            neg_lo      <= 1'b0;
            neg_hi      <= 1'b0;
            a_orig      <= '0;
            opnd        <= '0;
            acc         <= '0;
            hi          <= '0;
            lo          <= '0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            done <= (state == FINISH);
            case (state)
                IDLE: if (start) begin
                    is_div      <= op[1];
                    neg_lo      <= a_neg ^ b_neg;
                    neg_hi      <= a_neg;
                    a_orig      <= inA;
                    opnd        <= op[1] ? b_mag : a_mag;
                    acc         <= {{N{1'b0}}, (op[1] ? a_mag : b_mag)};
                    count       <= '0;
                    div_by_zero <= 1'b0;
                end
                RUN: begin
                    acc   <= is_div ? div_next : mul_next;
                    count <= count + 1'b1;
                end
                FINISH: begin
                    hi          <= res_hi;
                    lo          <= res_lo;
                    div_by_zero <= res_dbz;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - scoreboard bench for mult_div_unit against a plain-arithmetic reference model
module tb_mult_div_unit;

    localparam int N = 32;
    localparam int LAT = N + 1;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [1:0]    op = 2'd0;
    logic [N-1:0]  inA = '0;
    logic [N-1:0]  inB = '0;
    logic          busy, done, div_by_zero;
    logic [N-1:0]  hi, lo;

    mult_div_unit #(.N(N), .CW(6)) dut (
        .clock(clock), .reset(reset), .start(start), .op(op),
        .inA(inA), .inB(inB), .busy(busy), .done(done),
        .hi(hi), .lo(lo), .div_by_zero(div_by_zero)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [N-1:0] hi;
        logic [N-1:0] lo;
        logic         dbz;
        int           cyc;
    } exp_t;

    exp_t          sb_q[$];
    int            n_vec = 0;
    int            n_err = 0;
    int            cyc = 0;
    int            busy_cnt = 0;
    logic [N-1:0]  last_hi = '0;
    logic [N-1:0]  last_lo = '0;

    always @(posedge clock) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [1:0] o, input logic [N-1:0] a, input logic [N-1:0] b);
        exp_t e;
        longint sa, sb, p;
        longint unsigned ua, ub, up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        e.dbz = 1'b0;
        e.cyc = 0;
        e.hi  = '0;
        e.lo  = '0;
        case (o)
            2'd0: begin p = sa * sb; e.hi = p[63:32]; e.lo = p[31:0]; end
            2'd1: begin up = ua * ub; e.hi = up[63:32]; e.lo = up[31:0]; end
            default: begin
                if (b == '0) begin
                    e.lo = '1; e.hi = a; e.dbz = 1'b1;
                end else if (o == 2'd2) begin
                    p = sa / sb; e.lo = p[31:0];
                    p = sa % sb; e.hi = p[31:0];
                end else begin
                    up = ua / ub; e.lo = up[31:0];
                    up = ua % ub; e.hi = up[31:0];
                end
            end
        endcase
        return e;
    endfunction

    // Monitor: pops an expectation on each done, checks latency and that hi/lo hold otherwise
    always @(negedge clock) begin
        if (reset) begin
            if (busy) busy_cnt++;
            if (done) begin
                if (sb_q.size() == 0) begin
                    chk("spurious_done", 1'b1, 1'b0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    chk("hi", hi, e.hi);
                    chk("lo", lo, e.lo);
                    chk("div_by_zero", div_by_zero, e.dbz);
                    chk("latency", cyc - e.cyc, LAT);
                    chk("busy_cycles", busy_cnt, LAT);
                    chk("busy_at_done", busy, 1'b0);
                    last_hi = e.hi;
                    last_lo = e.lo;
                end
                busy_cnt = 0;
            end else begin
                chk("hold_hi", hi, last_hi);
                chk("hold_lo", lo, last_lo);
            end
        end
    end

    task automatic issue(input logic [1:0] o, input logic [N-1:0] a, input logic [N-1:0] b);
        exp_t e;
        int t = 0;
        @(negedge clock);
        while (busy && t < 100) begin
            @(negedge clock);
            t++;
        end
        chk("issue_wait", busy, 1'b0);
        start = 1'b1; op = o; inA = a; inB = b;
        e = model(o, a, b);
        @(posedge clock);
        #1;
        start = 1'b0;
        op  = 2'($urandom);
        inA = $urandom;
        inB = $urandom;
        e.cyc = cyc;
        sb_q.push_back(e);
        chk("accept_busy", busy, 1'b1);
        chk("accept_dbz_clear", div_by_zero, 1'b0);
    endtask

    function automatic logic [N-1:0] pick();
        case ($urandom_range(0, 6))
            0: return '0;
            1: return 32'd1;
            2: return '1;
            3: return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #12;
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        chk("rst_dbz", div_by_zero, 1'b0);
        @(negedge clock);
        reset = 1'b1;

        issue(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        issue(2'd0, 32'hFFFF_FFFD, 32'd7);
        issue(2'd2, 32'hFFFF_FFF9, 32'd2);
        issue(2'd3, 32'd100, 32'd7);
        issue(2'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        issue(2'd3, 32'h1234, 32'd0);
        issue(2'd2, 32'hFFFF_FF00, 32'd0);
        issue(2'd0, 32'd5, 32'd6);

        // Start pulsed mid-operation must be ignored
        issue(2'd1, 32'd1000, 32'd3000);
        repeat (5) @(posedge clock);
        #1;
        start = 1'b1; op = 2'd3; inA = 32'd77; inB = 32'd5;
        @(posedge clock);
        #1;
        start = 1'b0;

        for (int i = 0; i < 40; i++)
            issue(2'($urandom), pick(), pick());

        // Asynchronous reset in the middle of a MULTU discards it
        issue(2'd1, 32'hFFFF_FFFF, 32'h0000_0003);
        repeat (10) @(posedge clock);
        #2;
        reset = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_done", done, 1'b0);
        chk("mid_rst_hi", hi, 32'd0);
        chk("mid_rst_lo", lo, 32'd0);
        sb_q.delete();
        last_hi = '0;
        last_lo = '0;
        busy_cnt = 0;
        @(negedge clock);
        reset = 1'b1;
        repeat (40) @(posedge clock);

        issue(2'd3, 32'd100, 32'd7);
        issue(2'd0, 32'h7FFF_FFFF, 32'h8000_0000);

        begin
            int t = 0;
            while (sb_q.size() != 0 && t < 200) begin
                @(negedge clock);
                t++;
            end
            chk("drain", sb_q.size(), 0);
        end
        repeat (3) @(posedge clock);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
Parametrised iterative multiply/divide unit, the sequential companion to the single-cycle ALU, for MULT/MULTU/DIV/DIVU. Operands are latched on a start pulse. The unit computes one bit per clock and writes the HI/LO result registers, which hold their values until the next operation completes. The datapath stalls on busy and reads hi/lo (MFHI/MFLO) after done.

Parameters:
N, 32, operand width and hi/lo register width (N >= 4)
CW, 6, iteration counter width (2^CW must be > N)

Ports:
clock  input  1  clock; all state changes on posedge
reset  input  1  asynchronous, active-low reset
start  input  1  request; sampled on posedge only while busy=0
op     input  2  0=MULT (signed), 1=MULTU, 2=DIV (signed), 3=DIVU
inA    input  N  multiplicand / dividend
inB    input  N  multiplier / divisor
busy   output 1  operation in progress; start ignored while 1
done   output 1  one-cycle pulse; hi/lo/div_by_zero valid from this cycle
hi     output N  MULT: product[2N-1:N]; DIV: remainder
lo     output N  MULT: product[N-1:0]; DIV: quotient
div_by_zero output 1  set with done when DIV/DIVU had inB==0; cleared at next accepted start

Behaviour:
- Reset (reset==0, asynchronous, any state):
  - state=IDLE; busy=0, done=0, hi=0, lo=0, div_by_zero=0; counter=0.
  - An operation in flight is discarded and leaves no partial result.
- States: IDLE, RUN, FINISH.
- IDLE:
  - start==1 at posedge E0 latches op, |inA|, |inB| (magnitudes for signed ops) and the result signs.
  - Accumulator and counter are cleared, div_by_zero=0, then state goes to RUN.
  - busy=1 after E0.
- RUN: one iteration per posedge E1..EN, counter 0..N-1.
  - Multiply: shift-add on a 2N-bit accumulator, unsigned on the magnitudes.
  - Divide: restoring shift-subtract; quotient bit = 1 when the partial remainder >= divisor.
  - After EN (counter==N-1 at the edge), state goes to FINISH.
- FINISH, at posedge EN+1:
  - Apply sign correction, write hi/lo, done=1, busy=0, state=IDLE.
- Latency: start at E0 gives done=1 and a valid result in the cycle after E(N+1). That is N+1 cycles of busy, independent of operand values.
- done stays high exactly one cycle. hi/lo hold until the next FINISH; they do not change during RUN.
- start in the done cycle is accepted (state is IDLE), so back-to-back operations need no gap.
- start while busy=1 is ignored and has no effect on inputs latched earlier. inA/inB/op may change freely after E0.
- Signed multiply: product = sign-corrected 2N-bit two's complement.
- Signed divide:
  - Quotient truncates toward zero.
  - Remainder takes the sign of the dividend.
  - Overflow case (-2^(N-1) / -1): lo = 2^(N-1) bit pattern, hi = 0, no flag.
- Divide by zero (op 2/3, inB==0):
  - Full latency still applies.
  - lo = all ones, hi = inA as latched (original signed value for op 2), div_by_zero=1.
- MULT/MULTU always leave div_by_zero=0.
- Unsigned ops treat inA/inB as 0..2^N-1, with no sign correction.

Test Plan:
- Reset: assert reset mid-RUN of a MULTU -> busy=0, done=0, hi=lo=0 immediately (asynchronous); no done pulse afterwards.
- MULTU inA=0xFFFFFFFF, inB=0xFFFFFFFF (N=32):
  - hi=0xFFFFFFFE, lo=0x00000001.
  - done exactly 33 cycles after the start edge; busy high those 33 cycles.
- MULT inA=-3 (0xFFFFFFFD), inB=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- DIV cases:
  - inA=-7, inB=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
  - DIVU inA=100, inB=7 -> lo=14, hi=2.
  - DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU inA=0x1234, inB=0 -> lo=0xFFFFFFFF, hi=0x1234, div_by_zero=1 with done.
  - Next accepted start clears div_by_zero.
- Handshake:
  - Pulse start again 5 cycles into an op with different operands -> ignored; the result matches the first operands.
  - Start in the done cycle -> second done 33 cycles later; hi/lo hold the first result until then.
